// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
// window_gen_3x3 : raster pixel stream -> 3x3 sliding windows (valid conv).
// Optional frame_done pulse enabled by `define WINDOW_FRAME_DONE_EN.
// Rev 1.0
// ============================================================================
module window_gen_3x3 #(
  parameter int IMG_H  = 28,
  parameter int IMG_W  = 28,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_pixel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [9*DATA_W-1:0]      out_window,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef WINDOW_FRAME_DONE_EN
  ,
  output logic                     frame_done
`endif
);

  localparam int c_rw = $clog2(IMG_H);
  localparam int c_cw = $clog2(IMG_W);
  localparam logic [c_rw-1:0] c_row_last = c_rw'(IMG_H - 1);
  localparam logic [c_cw-1:0] c_col_last = c_cw'(IMG_W - 1);
  localparam logic [c_rw-1:0] c_two_r    = c_rw'(2);
  localparam logic [c_cw-1:0] c_two_c    = c_cw'(2);

  logic [c_cw-1:0]       col_q, col_d;
  logic [c_rw-1:0]       row_q, row_d;
  // Columns 1 and 2 of the sliding window; column 0 is shifted out on accept.
  logic [6*DATA_W-1:0]   hist_q, hist_d;
  logic [9*DATA_W-1:0]   out_window_q, out_window_d;
  logic [c_rw-1:0]       out_row_q, out_row_d;
  logic [c_cw-1:0]       out_col_q, out_col_d;
  logic                  out_valid_q, out_valid_d;

  logic [DATA_W-1:0]     linebuf0_q [IMG_W];
  logic [DATA_W-1:0]     linebuf1_q [IMG_W];

  logic                  w_accept;
  logic [DATA_W-1:0]     w_lb0_rd;
  logic [DATA_W-1:0]     w_lb1_rd;
  logic [3*DATA_W-1:0]   w_new_col;
  logic [9*DATA_W-1:0]   w_win_shift;

  assign in_ready  = !out_valid_q || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_lb0_rd  = linebuf0_q[col_q];
  assign w_lb1_rd  = linebuf1_q[col_q];
  assign w_new_col = {in_pixel, w_lb1_rd, w_lb0_rd};

  always_comb begin
    w_win_shift = '0;
    for (int i = 0; i < 3; i++) begin
      w_win_shift[DATA_W*(3*i)   +: DATA_W] = hist_q[DATA_W*(2*i)   +: DATA_W];
      w_win_shift[DATA_W*(3*i+1) +: DATA_W] = hist_q[DATA_W*(2*i+1) +: DATA_W];
      w_win_shift[DATA_W*(3*i+2) +: DATA_W] = w_new_col[DATA_W*i +: DATA_W];
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hist_d       = hist_q;
    out_window_d = out_window_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    out_valid_d  = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        hist_d[DATA_W*(2*i)   +: DATA_W] = hist_q[DATA_W*(2*i+1) +: DATA_W];
        hist_d[DATA_W*(2*i+1) +: DATA_W] = w_new_col[DATA_W*i +: DATA_W];
      end
      if (col_q == c_col_last) begin
        col_d = '0;
        row_d = (row_q == c_row_last) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // A fresh window overrides a same-cycle drain, keeping out_valid high.
      if (row_q >= c_two_r && col_q >= c_two_c) begin
        out_window_d = w_win_shift;
        out_row_d    = row_q - c_two_r;
        out_col_d    = col_q - c_two_c;
        out_valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hist_q       <= '0;
      out_window_q <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hist_q       <= hist_d;
      out_window_q <= out_window_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Line buffers need no reset: stale rows never reach a window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      linebuf0_q[col_q] <= w_lb1_rd;
      linebuf1_q[col_q] <= in_pixel;
    end
  end

  assign out_window = out_window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_valid  = out_valid_q;

`ifdef WINDOW_FRAME_DONE_EN
  localparam logic [c_rw-1:0] c_row_lastwin = c_rw'(IMG_H - 3);
  localparam logic [c_cw-1:0] c_col_lastwin = c_cw'(IMG_W - 3);

  logic frame_done_q, frame_done_d;

  always_comb begin
    frame_done_d = out_valid_q && out_ready &&
                   (out_row_q == c_row_lastwin) && (out_col_q == c_col_lastwin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
`endif

endmodule
`default_nettype wire
